// File: rtl/decode_stage_hz.sv
// decode_stage_hz: ID stage of the 5-stage core.
// Decodes the IF/ID instruction, drives the regfile read addresses,
// detects load-use and multiply-result hazards, and registers the ID/EX boundary.
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   in_valid, pc, instruction - IF/ID contents
//   flush, ext_stall          - redirect squash / downstream hold
//   ex_memread, ex_dest_reg   - load in EX, for load-use detection
//   src_reg1/2, rin_reg1/2    - regfile read address / data
//   stall_out                 - hold PC and IF/ID (combinational)
//   is_jump, jump_addr        - early jump redirect (combinational)
//   out_*, rout_*, dest_reg, imm, op_code, funct_code, is_mult, control bits
//                             - ID/EX registers
module decode_stage_hz #(
    parameter int ADDR_W         = 32,
    parameter int INSTR_W        = 32,
    parameter int REG_W          = 32,
    parameter int REG_AW         = 5,
    parameter int MULT_LAT       = 5,
    parameter bit IMM_ZEXT_LOGIC = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               flush,
    input  logic               ext_stall,
    input  logic               ex_memread,
    input  logic [REG_AW-1:0]  ex_dest_reg,
    output logic [REG_AW-1:0]  src_reg1,
    output logic [REG_AW-1:0]  src_reg2,
    input  logic [REG_W-1:0]   rin_reg1,
    input  logic [REG_W-1:0]   rin_reg2,
    output logic               stall_out,
    output logic               is_jump,
    output logic [ADDR_W-1:0]  jump_addr,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [REG_AW-1:0]  out_addr_reg1,
    output logic [REG_AW-1:0]  out_addr_reg2,
    output logic [REG_W-1:0]   rout_reg1,
    output logic [REG_W-1:0]   rout_reg2,
    output logic [REG_AW-1:0]  dest_reg,
    output logic [ADDR_W-1:0]  imm,
    output logic [5:0]         op_code,
    output logic [5:0]         funct_code,
    output logic               is_mult,
    output logic               regwrite,
    output logic               memtoreg,
    output logic               memread,
    output logic               memwrite,
    output logic               byteword,
    output logic               alusrc
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LDB   = 6'h20;
    localparam logic [5:0] OP_LDW   = 6'h23;
    localparam logic [5:0] OP_STB   = 6'h28;
    localparam logic [5:0] OP_STW   = 6'h2B;
    localparam logic [5:0] FN_MUL   = 6'h18;

    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_LAT - 1);

    logic [5:0]        opc, fn;
    logic [REG_AW-1:0] rs, rt, rd;
    logic is_rtype, is_load, is_store, is_imm_alu, is_logic_imm, is_branch;
    logic rt_src, dec_is_mul;
    logic [REG_AW-1:0] dec_dest;
    logic [ADDR_W-1:0] dec_imm;
    logic load_hz, mult_hz, take, mul_issue, mul_busy;
    logic [CNT_W-1:0]  mul_cnt;
    logic [REG_AW-1:0] mul_dst;

    assign opc = instruction[31:26];
    assign rs  = instruction[25:21];
    assign rt  = instruction[20:16];
    assign rd  = instruction[15:11];
    assign fn  = instruction[5:0];

    assign src_reg1 = rs;
    assign src_reg2 = rt;

    assign is_rtype     = (opc == OP_RTYPE);
    assign is_load      = (opc == OP_LDW) || (opc == OP_LDB);
    assign is_store     = (opc == OP_STW) || (opc == OP_STB);
    assign is_logic_imm = (opc == OP_ANDI) || (opc == OP_ORI) || (opc == OP_XORI);
    assign is_imm_alu   = (opc == OP_ADDI) || (opc == OP_SLTI) || is_logic_imm;
    assign is_branch    = (opc == OP_BEQ) || (opc == OP_BNE);
    // rt is read as data by R-type, stores (store data) and branches (compare)
    assign rt_src       = is_rtype || is_store || is_branch;
    assign dec_is_mul   = is_rtype && (fn == FN_MUL);

    assign dec_dest = (is_load || is_imm_alu) ? rt :
                      is_rtype                ? rd : '0;

    assign dec_imm = (IMM_ZEXT_LOGIC && is_logic_imm)
                   ? {{(ADDR_W-16){1'b0}}, instruction[15:0]}
                   : {{(ADDR_W-16){instruction[15]}}, instruction[15:0]};

    assign is_jump   = in_valid && (opc == OP_JUMP) && !flush;
    assign jump_addr = {pc[ADDR_W-1:28], instruction[25:0], 2'b00};

    assign load_hz = in_valid && ex_memread && (ex_dest_reg != '0) &&
                     ((ex_dest_reg == rs) || (rt_src && (ex_dest_reg == rt)));

    assign mul_busy = (mul_cnt != '0);
    assign mult_hz  = in_valid && mul_busy && (mul_dst != '0) &&
                      ((mul_dst == rs) || (rt_src && (mul_dst == rt)));

    assign stall_out = !flush && (ext_stall || load_hz || mult_hz);

    // An instruction really moves into EX only when none of the bubble causes apply
    assign take      = in_valid && !flush && !load_hz && !mult_hz;
    assign mul_issue = take && dec_is_mul && !ext_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_cnt       <= '0;
            mul_dst       <= '0;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_addr_reg1 <= '0;
            out_addr_reg2 <= '0;
            rout_reg1     <= '0;
            rout_reg2     <= '0;
            dest_reg      <= '0;
            imm           <= '0;
            op_code       <= '0;
            funct_code    <= '0;
            is_mult       <= 1'b0;
            regwrite      <= 1'b0;
            memtoreg      <= 1'b0;
            memread       <= 1'b0;
            memwrite      <= 1'b0;
            byteword      <= 1'b0;
            alusrc        <= 1'b0;
        end else begin
            // scoreboard keeps counting even while EX is held
            if (mul_issue) begin
                mul_cnt <= MUL_LOAD;
                mul_dst <= dec_dest;
            end else if (mul_busy) begin
                mul_cnt <= mul_cnt - CNT_W'(1);
            end

            if (!ext_stall) begin
                out_valid     <= take;
                out_pc        <= pc;
                out_addr_reg1 <= rs;
                out_addr_reg2 <= rt_src ? rt : '0;
                rout_reg1     <= rin_reg1;
                rout_reg2     <= rin_reg2;
                dest_reg      <= dec_dest;
                imm           <= dec_imm;
                op_code       <= opc;
                funct_code    <= fn;
                is_mult       <= take && dec_is_mul;
                regwrite      <= take && (is_load || is_imm_alu || is_rtype) && (dec_dest != '0);
                memtoreg      <= take && is_load;
                memread       <= take && is_load;
                memwrite      <= take && is_store;
                byteword      <= take && ((opc == OP_LDB) || (opc == OP_STB));
                alusrc        <= take && (is_load || is_store || is_imm_alu);
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz (default parameters, MULT_LAT=5).
module tb_decode_stage_hz;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        flush, ext_stall, ex_memread;
    logic [4:0]  ex_dest_reg;
    logic [4:0]  src_reg1, src_reg2;
    logic [31:0] rin_reg1, rin_reg2;
    logic        stall_out, is_jump;
    logic [31:0] jump_addr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [4:0]  out_addr_reg1, out_addr_reg2;
    logic [31:0] rout_reg1, rout_reg2;
    logic [4:0]  dest_reg;
    logic [31:0] imm;
    logic [5:0]  op_code, funct_code;
    logic        is_mult, regwrite, memtoreg, memread, memwrite, byteword, alusrc;

    int n_chk = 0;
    int n_err = 0;

    decode_stage_hz dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc(pc), .instruction(instruction),
        .flush(flush), .ext_stall(ext_stall), .ex_memread(ex_memread), .ex_dest_reg(ex_dest_reg),
        .src_reg1(src_reg1), .src_reg2(src_reg2), .rin_reg1(rin_reg1), .rin_reg2(rin_reg2),
        .stall_out(stall_out), .is_jump(is_jump), .jump_addr(jump_addr),
        .out_valid(out_valid), .out_pc(out_pc), .out_addr_reg1(out_addr_reg1),
        .out_addr_reg2(out_addr_reg2), .rout_reg1(rout_reg1), .rout_reg2(rout_reg2),
        .dest_reg(dest_reg), .imm(imm), .op_code(op_code), .funct_code(funct_code),
        .is_mult(is_mult), .regwrite(regwrite), .memtoreg(memtoreg), .memread(memread),
        .memwrite(memwrite), .byteword(byteword), .alusrc(alusrc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int fn);
        r_ins = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int im);
        i_ins = {6'(op), 5'(rs), 5'(rt), 16'(im)};
    endfunction

    task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] ins);
        in_valid    = v;
        pc          = p;
        instruction = ins;
    endtask

    initial begin
        int n;
        reset = 1'b1; in_valid = 0; pc = '0; instruction = '0; flush = 0; ext_stall = 0;
        ex_memread = 0; ex_dest_reg = '0; rin_reg1 = 32'h1111; rin_reg2 = 32'h2222;
        tick; tick;
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_regwrite", regwrite, 0);
        chk("rst_imm", imm, 0);
        chk("rst_mulcnt", dut.mul_cnt, 0);
        #1 chk("rst_stall", stall_out, 0);

        // load-use on rs
        drive(1, 32'h10, r_ins(3, 6, 5, 'h20));
        ex_memread = 1; ex_dest_reg = 3;
        #1 chk("lu_stall", stall_out, 1);
        chk("lu_src1", src_reg1, 3);
        tick;
        chk("lu_bubble", out_valid, 0);
        chk("lu_bubble_rw", regwrite, 0);
        ex_memread = 0; ex_dest_reg = 0;
        #1 chk("lu_release", stall_out, 0);
        tick;
        chk("lu_valid", out_valid, 1);
        chk("lu_rout1", rout_reg1, 32'h1111);
        chk("lu_dest", dest_reg, 5);
        chk("lu_rw", regwrite, 1);
        chk("lu_addr2", out_addr_reg2, 6);

        // rt of ADDI is a destination, not a source
        drive(1, 32'h14, i_ins('h08, 1, 3, 7));
        ex_memread = 1; ex_dest_reg = 3;
        #1 chk("lu_rt_nosrc", stall_out, 0);
        tick;
        chk("addi_valid", out_valid, 1);
        chk("addi_addr2", out_addr_reg2, 0);
        // register 0 never hazards
        drive(1, 32'h18, r_ins(0, 0, 1, 'h20));
        ex_dest_reg = 0;
        #1 chk("lu_r0", stall_out, 0);
        // not valid -> no hazard, bubble
        drive(0, 32'h1c, r_ins(3, 6, 5, 'h20));
        ex_dest_reg = 3;
        #1 chk("inv_nostall", stall_out, 0);
        tick;
        chk("inv_bubble", out_valid, 0);
        ex_memread = 0; ex_dest_reg = 0;

        // mult scoreboard
        drive(1, 32'h20, r_ins(1, 2, 4, 'h18));
        tick;
        chk("mul_ismult", is_mult, 1);
        chk("mul_valid", out_valid, 1);
        chk("mul_cnt_load", dut.mul_cnt, 4);
        drive(1, 32'h24, r_ins(4, 5, 6, 'h20));
        n = 0;
        #1;
        while (stall_out && n < 10) begin
            n++;
            tick;
            #1;
        end
        chk("mul_stall_len", n, 4);
        tick;
        chk("mul_dep_valid", out_valid, 1);
        chk("mul_dep_dest", dest_reg, 6);
        drive(1, 32'h28, r_ins(1, 2, 4, 'h18));
        tick;
        drive(1, 32'h2c, r_ins(7, 8, 9, 'h20));
        #1 chk("mul_indep", stall_out, 0);
        tick;
        chk("mul_indep_dest", dest_reg, 9);
        drive(0, 32'h0, 32'h0);
        repeat (5) tick;
        chk("mul_drain", dut.mul_cnt, 0);

        // immediates and memory controls
        drive(1, 32'h30, i_ins('h08, 1, 2, 'hFFF0));
        tick;
        chk("addi_imm", imm, 32'hFFFFFFF0);
        chk("addi_dest", dest_reg, 2);
        chk("addi_alusrc", alusrc, 1);
        drive(1, 32'h34, i_ins('h0D, 1, 2, 'hFFF0));
        tick;
        chk("ori_imm", imm, 32'h0000FFF0);
        drive(1, 32'h38, i_ins('h23, 1, 9, 4));
        tick;
        chk("ldw_dest", dest_reg, 9);
        chk("ldw_memread", memread, 1);
        chk("ldw_memtoreg", memtoreg, 1);
        chk("ldw_rw", regwrite, 1);
        chk("ldw_byte", byteword, 0);
        drive(1, 32'h3c, i_ins('h28, 1, 9, 4));
        tick;
        chk("stb_memwrite", memwrite, 1);
        chk("stb_byte", byteword, 1);
        chk("stb_rw", regwrite, 0);
        chk("stb_dest", dest_reg, 0);
        chk("stb_addr2", out_addr_reg2, 9);
        drive(1, 32'h40, i_ins('h08, 1, 0, 5));
        tick;
        chk("addi_r0_rw", regwrite, 0);

        // jump
        drive(1, 32'h40000010, {6'h02, 26'h100});
        #1 chk("j_isjump", is_jump, 1);
        chk("j_addr", jump_addr, 32'h40000400);
        tick;
        chk("j_valid", out_valid, 1);
        chk("j_rw", regwrite, 0);
        flush = 1;
        #1 chk("jf_isjump", is_jump, 0);
        tick;
        chk("jf_bubble", out_valid, 0);
        // flush overrides load-use hazard
        drive(1, 32'h44, r_ins(3, 6, 5, 'h20));
        ex_memread = 1; ex_dest_reg = 3;
        #1 chk("flush_nostall", stall_out, 0);
        tick;
        chk("flush_bubble", out_valid, 0);
        ex_memread = 0; ex_dest_reg = 0;
        // flushed mul must not arm the scoreboard
        drive(1, 32'h48, r_ins(1, 2, 4, 'h18));
        tick;
        chk("flush_mul_cnt", dut.mul_cnt, 0);
        flush = 0;
        drive(1, 32'h4c, r_ins(4, 5, 6, 'h20));
        #1 chk("flush_mul_nostall", stall_out, 0);
        tick;

        // ext_stall freezes ID/EX while the scoreboard counts
        drive(1, 32'h100, r_ins(1, 2, 4, 'h18));
        tick;
        ext_stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h200 + 32'(i), r_ins(4, 5, 10 + i, 'h20));
            #1 chk("es_stall", stall_out, 1);
            tick;
            chk("es_pc", out_pc, 32'h100);
            chk("es_dest", dest_reg, 4);
            chk("es_ismult", is_mult, 1);
            chk("es_cnt", dut.mul_cnt, 64'(3 - i));
        end
        ext_stall = 0;
        #1 chk("es_tail_stall", stall_out, 1);
        tick;
        chk("es_tail_bubble", out_valid, 0);
        #1 chk("es_release", stall_out, 0);
        tick;
        chk("es_issue", out_valid, 1);
        chk("es_issue_dest", dest_reg, 12);

        // reset during a mult stall
        drive(1, 32'h300, r_ins(1, 2, 4, 'h18));
        tick;
        drive(1, 32'h304, r_ins(4, 5, 6, 'h20));
        #1 chk("rs_pre_stall", stall_out, 1);
        reset = 1;
        tick;
        reset = 0;
        chk("rs_valid", out_valid, 0);
        chk("rs_rw", regwrite, 0);
        chk("rs_cnt", dut.mul_cnt, 0);
        #1 chk("rs_stall", stall_out, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
